// File: rtl/axi4_lite_mem_nslave_if.sv
// AXI4-Lite bus bundle for axi4_lite_mem_nslave: word-addressed, one outstanding
// transaction per direction.
interface axi4_lite_mem_nslave_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
);
  logic [ADDR_W-1:0]   AWADDR;
  logic                AWVALID;
  logic                AWREADY;
  logic [DATA_W-1:0]   WDATA;
  logic [DATA_W/8-1:0] WSTRB;
  logic                WVALID;
  logic                WREADY;
  logic [1:0]          BRESP;
  logic                BVALID;
  logic                BREADY;
  logic [ADDR_W-1:0]   ARADDR;
  logic                ARVALID;
  logic                ARREADY;
  logic [DATA_W-1:0]   RDATA;
  logic [1:0]          RRESP;
  logic                RVALID;
  logic                RREADY;

  modport slave (
    input  AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
    output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );

  modport master (
    output AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
    input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );
endinterface

// File: rtl/axi4_lite_mem_nslave.sv
// AXI4-Lite memory slave split into NUM_REGIONS equal regions with per-region
// read-only protection, SLVERR/DECERR responses and saturating error counters.
module axi4_lite_mem_nslave #(
  parameter int                     DATA_W       = 32,
  parameter int                     ADDR_W       = 10,
  parameter int                     NUM_REGIONS  = 4,
  parameter int                     REGION_WORDS = 128,
  parameter logic [NUM_REGIONS-1:0] RO_MASK      = 4'b1000
) (
  input  logic                        ACLK,
  input  logic                        ARESETN,
  axi4_lite_mem_nslave_if.slave       bus,
  output logic [7:0]                  wr_err_cnt,
  output logic [7:0]                  rd_err_cnt
);

  localparam int STRB_W = DATA_W / 8;
  localparam int RA     = $clog2(REGION_WORDS);
  localparam int DEPTH  = NUM_REGIONS * REGION_WORDS;
  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {W_IDLE, W_HAVE_A, W_HAVE_D, W_RESP} w_state_e;
  typedef enum logic       {R_IDLE, R_RESP}                     r_state_e;

  function automatic logic [1:0] decode(input logic [ADDR_W-1:0] addr, input logic is_wr);
    logic [ADDR_W-1:0] rgn;
    logic              ro;
    rgn = addr >> RA;
    ro  = 1'b0;
    for (int r = 0; r < NUM_REGIONS; r++)
      if (rgn == ADDR_W'(r)) ro = RO_MASK[r];
    if (rgn >= ADDR_W'(NUM_REGIONS)) return RESP_DECERR;
    if (is_wr && ro)                 return RESP_SLVERR;
    return RESP_OKAY;
  endfunction

  logic [DATA_W-1:0] mem [DEPTH];

  // ---------------- write path ----------------
  w_state_e          w_state_q, w_state_d;
  logic [ADDR_W-1:0] aw_addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [STRB_W-1:0] wstrb_q;
  logic              aw_hs, w_hs;
  logic              commit;
  logic [ADDR_W-1:0] cm_addr;
  logic [DATA_W-1:0] cm_data;
  logic [STRB_W-1:0] cm_strb;
  logic [1:0]        cm_resp;

  assign aw_hs = bus.AWVALID && bus.AWREADY;
  assign w_hs  = bus.WVALID  && bus.WREADY;

  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis would infer a latch to hold the old value.
  always_comb begin
    w_state_d = w_state_q;
    commit    = 1'b0;
    cm_addr   = aw_addr_q;
    cm_data   = wdata_q;
    cm_strb   = wstrb_q;
    unique case (w_state_q)
      W_IDLE: begin
        if (aw_hs && w_hs) begin
          commit    = 1'b1;
          cm_addr   = bus.AWADDR;
          cm_data   = bus.WDATA;
          cm_strb   = bus.WSTRB;
          w_state_d = W_RESP;
        end else if (aw_hs) begin
          w_state_d = W_HAVE_A;
        end else if (w_hs) begin
          w_state_d = W_HAVE_D;
        end
      end
      W_HAVE_A: if (w_hs) begin
        commit    = 1'b1;
        cm_data   = bus.WDATA;
        cm_strb   = bus.WSTRB;
        w_state_d = W_RESP;
      end
      W_HAVE_D: if (aw_hs) begin
        commit    = 1'b1;
        cm_addr   = bus.AWADDR;
        w_state_d = W_RESP;
      end
      W_RESP: if (bus.BVALID && bus.BREADY) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  assign cm_resp = decode(cm_addr, 1'b1);

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // pre-edge values; blocking '=' is reserved for the combinational block above.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      w_state_q   <= W_IDLE;
      aw_addr_q   <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      bus.AWREADY <= 1'b0;
      bus.WREADY  <= 1'b0;
      bus.BVALID  <= 1'b0;
      bus.BRESP   <= RESP_OKAY;
      wr_err_cnt  <= '0;
    end else begin
      w_state_q   <= w_state_d;
      if (aw_hs) aw_addr_q <= bus.AWADDR;
      if (w_hs) begin
        wdata_q <= bus.WDATA;
        wstrb_q <= bus.WSTRB;
      end
      // Readies are registered from the next state so no input reaches an output.
      bus.AWREADY <= (w_state_d == W_IDLE) || (w_state_d == W_HAVE_D);
      bus.WREADY  <= (w_state_d == W_IDLE) || (w_state_d == W_HAVE_A);
      bus.BVALID  <= (w_state_d == W_RESP);
      if (commit) begin
        bus.BRESP <= cm_resp;
        if (cm_resp != RESP_OKAY && wr_err_cnt != 8'hFF) wr_err_cnt <= wr_err_cnt + 8'd1;
      end
    end
  end

  // NOTE: the storage array has no reset; clearing it would turn the RAM into
  // a flop bank, and software initialises it by writing.
  always_ff @(posedge ACLK) begin
    if (commit && cm_resp == RESP_OKAY) begin
      for (int i = 0; i < STRB_W; i++)
        if (cm_strb[i]) mem[cm_addr[IDX_W-1:0]][8*i +: 8] <= cm_data[8*i +: 8];
    end
  end

  // ---------------- read path ----------------
  r_state_e   r_state_q, r_state_d;
  logic       ar_hs;
  logic [1:0] ar_resp;

  assign ar_hs   = bus.ARVALID && bus.ARREADY;
  assign ar_resp = decode(bus.ARADDR, 1'b0);

  always_comb begin
    r_state_d = r_state_q;
    unique case (r_state_q)
      R_IDLE:  if (ar_hs) r_state_d = R_RESP;
      R_RESP:  if (bus.RVALID && bus.RREADY) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_state_q   <= R_IDLE;
      bus.ARREADY <= 1'b0;
      bus.RVALID  <= 1'b0;
      bus.RRESP   <= RESP_OKAY;
      bus.RDATA   <= '0;
      rd_err_cnt  <= '0;
    end else begin
      r_state_q   <= r_state_d;
      bus.ARREADY <= (r_state_d == R_IDLE);
      bus.RVALID  <= (r_state_d == R_RESP);
      if (ar_hs) begin
        // Same-edge write commits land after this sample, so the old word is returned.
        bus.RRESP <= ar_resp;
        bus.RDATA <= (ar_resp == RESP_OKAY) ? mem[bus.ARADDR[IDX_W-1:0]] : '0;
        if (ar_resp != RESP_OKAY && rd_err_cnt != 8'hFF) rd_err_cnt <= rd_err_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_axi4_lite_mem_nslave.sv
// Directed bench for axi4_lite_mem_nslave with default parameters: region 3
// (0x180-0x1FF) is read-only and 0x200+ decodes to DECERR.
module tb_axi4_lite_mem_nslave;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] wr_err_cnt, rd_err_cnt;
  int         checks = 0;
  int         errors = 0;

  axi4_lite_mem_nslave_if #(.DATA_W(32), .ADDR_W(10)) bus ();

  axi4_lite_mem_nslave #(
    .DATA_W(32), .ADDR_W(10), .NUM_REGIONS(4), .REGION_WORDS(128), .RO_MASK(4'b1000)
  ) dut (
    .ACLK      (clk),
    .ARESETN   (rst_n),
    .bus       (bus),
    .wr_err_cnt(wr_err_cnt),
    .rd_err_cnt(rd_err_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at a negedge after the B handshake.
  task automatic do_write(input logic [9:0] a, input logic [31:0] d, input logic [3:0] s,
                          output logic [1:0] resp);
    logic aw_pend, w_pend, aw_go, w_go;
    int   n;
    bus.AWADDR = a; bus.WDATA = d; bus.WSTRB = s;
    bus.AWVALID = 1'b1; bus.WVALID = 1'b1; bus.BREADY = 1'b1;
    aw_pend = 1'b1; w_pend = 1'b1; n = 0;
    while ((aw_pend || w_pend) && n < 20) begin
      aw_go = bus.AWVALID && bus.AWREADY;
      w_go  = bus.WVALID && bus.WREADY;
      @(negedge clk);
      if (aw_go) begin bus.AWVALID = 1'b0; aw_pend = 1'b0; end
      if (w_go)  begin bus.WVALID  = 1'b0; w_pend  = 1'b0; end
      n++;
    end
    check("wr_accept", {aw_pend, w_pend}, 2'b00);
    n = 0;
    while (!bus.BVALID && n < 20) begin @(negedge clk); n++; end
    check("wr_bvalid_seen", bus.BVALID, 1'b1);
    resp = bus.BRESP;
    @(negedge clk);
    bus.BREADY = 1'b0;
    bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
  endtask

  task automatic do_read(input logic [9:0] a, output logic [31:0] d, output logic [1:0] resp);
    int n;
    bus.ARADDR = a; bus.ARVALID = 1'b1; bus.RREADY = 1'b1;
    n = 0;
    while (!bus.ARREADY && n < 20) begin @(negedge clk); n++; end
    check("rd_arready_seen", bus.ARREADY, 1'b1);
    @(negedge clk);
    bus.ARVALID = 1'b0;
    n = 0;
    while (!bus.RVALID && n < 20) begin @(negedge clk); n++; end
    check("rd_rvalid_seen", bus.RVALID, 1'b1);
    d = bus.RDATA; resp = bus.RRESP;
    @(negedge clk);
    bus.RREADY = 1'b0;
  endtask

  initial begin
    logic [31:0] rd, rd_before;
    logic [1:0]  rs;

    rst_n = 1'b0;
    bus.AWADDR = '0; bus.AWVALID = 1'b0; bus.WDATA = '0; bus.WSTRB = '0; bus.WVALID = 1'b0;
    bus.BREADY = 1'b0; bus.ARADDR = '0; bus.ARVALID = 1'b0; bus.RREADY = 1'b0;

    // Reset state and release
    @(negedge clk);
    check("rst_awready", bus.AWREADY, 1'b0);
    check("rst_wready",  bus.WREADY,  1'b0);
    check("rst_arready", bus.ARREADY, 1'b0);
    check("rst_bvalid",  bus.BVALID,  1'b0);
    check("rst_rvalid",  bus.RVALID,  1'b0);
    check("rst_bresp",   bus.BRESP,   2'b00);
    check("rst_rresp",   bus.RRESP,   2'b00);
    check("rst_rdata",   bus.RDATA,   32'h0);
    check("rst_wr_cnt",  wr_err_cnt,  8'd0);
    check("rst_rd_cnt",  rd_err_cnt,  8'd0);
    rst_n = 1'b1;
    #1;
    check("rel_awready_pre", bus.AWREADY, 1'b0);
    check("rel_arready_pre", bus.ARREADY, 1'b0);
    @(negedge clk);
    check("rel_awready", bus.AWREADY, 1'b1);
    check("rel_wready",  bus.WREADY,  1'b1);
    check("rel_arready", bus.ARREADY, 1'b1);

    // Full write, AW and W in the same cycle
    bus.AWADDR = 10'h085; bus.WDATA = 32'hDEADBEEF; bus.WSTRB = 4'hF;
    bus.AWVALID = 1'b1; bus.WVALID = 1'b1;
    @(negedge clk);
    bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
    check("wr1_bvalid",  bus.BVALID,  1'b1);
    check("wr1_bresp",   bus.BRESP,   2'b00);
    check("wr1_awready", bus.AWREADY, 1'b0);
    check("wr1_wready",  bus.WREADY,  1'b0);
    bus.BREADY = 1'b1;
    @(negedge clk);
    bus.BREADY = 1'b0;
    check("wr1_bvalid_done", bus.BVALID,  1'b0);
    check("wr1_awready_bk",  bus.AWREADY, 1'b1);

    bus.ARADDR = 10'h085; bus.ARVALID = 1'b1;
    @(negedge clk);
    bus.ARVALID = 1'b0;
    check("rd1_rvalid",  bus.RVALID,  1'b1);
    check("rd1_rdata",   bus.RDATA,   32'hDEADBEEF);
    check("rd1_rresp",   bus.RRESP,   2'b00);
    check("rd1_arready", bus.ARREADY, 1'b0);
    bus.RREADY = 1'b1;
    @(negedge clk);
    bus.RREADY = 1'b0;
    check("rd1_rvalid_done", bus.RVALID,  1'b0);
    check("rd1_arready_bk",  bus.ARREADY, 1'b1);

    // W before AW with a partial strobe
    do_write(10'h010, 32'h11223344, 4'hF, rs);
    check("init010_bresp", rs, 2'b00);
    bus.WDATA = 32'hAABBCCDD; bus.WSTRB = 4'b0101; bus.WVALID = 1'b1;
    @(negedge clk);
    bus.WVALID = 1'b0;
    check("wfirst_wready",  bus.WREADY,  1'b0);
    check("wfirst_awready", bus.AWREADY, 1'b1);
    check("wfirst_bvalid",  bus.BVALID,  1'b0);
    @(negedge clk);
    @(negedge clk);
    bus.AWADDR = 10'h010; bus.AWVALID = 1'b1;
    @(negedge clk);
    bus.AWVALID = 1'b0;
    check("wfirst_bvalid_after_aw", bus.BVALID, 1'b1);
    check("wfirst_bresp",           bus.BRESP,  2'b00);
    bus.BREADY = 1'b1;
    @(negedge clk);
    bus.BREADY = 1'b0;
    do_read(10'h010, rd, rs);
    check("strb_rdata", rd, 32'h11BB33DD);
    check("strb_rresp", rs, 2'b00);

    // Protection and decode errors
    do_read(10'h1A0, rd_before, rs);
    check("ro_read_rresp", rs, 2'b00);
    do_write(10'h1A0, 32'h5A5A5A5A, 4'hF, rs);
    check("ro_write_bresp", rs, 2'b10);
    do_read(10'h1A0, rd, rs);
    check("ro_unchanged", rd, rd_before);
    do_write(10'h205, 32'h12345678, 4'hF, rs);
    check("dec_write_bresp", rs, 2'b11);
    do_read(10'h3FF, rd, rs);
    check("dec_read_rdata", rd, 32'h0);
    check("dec_read_rresp", rs, 2'b11);
    check("wr_err_cnt_2", wr_err_cnt, 8'd2);
    check("rd_err_cnt_1", rd_err_cnt, 8'd1);

    // Backpressure: B and R held for 10 cycles
    bus.AWADDR = 10'h020; bus.WDATA = 32'hCAFEF00D; bus.WSTRB = 4'hF;
    bus.AWVALID = 1'b1; bus.WVALID = 1'b1;
    bus.ARADDR = 10'h085; bus.ARVALID = 1'b1;
    @(negedge clk);
    bus.AWVALID = 1'b0; bus.WVALID = 1'b0; bus.ARVALID = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check("bp_bvalid",  bus.BVALID,  1'b1);
      check("bp_bresp",   bus.BRESP,   2'b00);
      check("bp_rvalid",  bus.RVALID,  1'b1);
      check("bp_rdata",   bus.RDATA,   32'hDEADBEEF);
      check("bp_rresp",   bus.RRESP,   2'b00);
      check("bp_awready", bus.AWREADY, 1'b0);
      check("bp_wready",  bus.WREADY,  1'b0);
      check("bp_arready", bus.ARREADY, 1'b0);
      @(negedge clk);
    end
    bus.BREADY = 1'b1; bus.RREADY = 1'b1;
    @(negedge clk);
    bus.BREADY = 1'b0; bus.RREADY = 1'b0;
    check("bp_bvalid_done", bus.BVALID, 1'b0);
    check("bp_rvalid_done", bus.RVALID, 1'b0);
    do_read(10'h020, rd, rs);
    check("bp_write_landed", rd, 32'hCAFEF00D);

    // Read and write of the same word on the same edge
    do_write(10'h030, 32'h01010101, 4'hF, rs);
    check("conc_init_bresp", rs, 2'b00);
    bus.AWADDR = 10'h030; bus.WDATA = 32'h02020202; bus.WSTRB = 4'hF;
    bus.AWVALID = 1'b1; bus.WVALID = 1'b1;
    bus.ARADDR = 10'h030; bus.ARVALID = 1'b1;
    @(negedge clk);
    bus.AWVALID = 1'b0; bus.WVALID = 1'b0; bus.ARVALID = 1'b0;
    check("conc_bvalid", bus.BVALID, 1'b1);
    check("conc_rvalid", bus.RVALID, 1'b1);
    check("conc_old_data", bus.RDATA, 32'h01010101);
    bus.BREADY = 1'b1; bus.RREADY = 1'b1;
    @(negedge clk);
    bus.BREADY = 1'b0; bus.RREADY = 1'b0;
    do_read(10'h030, rd, rs);
    check("conc_new_data", rd, 32'h02020202);

    // Asynchronous reset while a write response is pending
    bus.AWADDR = 10'h040; bus.WDATA = 32'h0BADF00D; bus.WSTRB = 4'hF;
    bus.AWVALID = 1'b1; bus.WVALID = 1'b1;
    @(negedge clk);
    bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
    check("mid_bvalid_before", bus.BVALID, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_bvalid_async", bus.BVALID,  1'b0);
    check("mid_awready",      bus.AWREADY, 1'b0);
    check("mid_wr_cnt",       wr_err_cnt,  8'd0);
    check("mid_rd_cnt",       rd_err_cnt,  8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("mid_rel_awready", bus.AWREADY, 1'b1);
    check("mid_rel_arready", bus.ARREADY, 1'b1);
    do_write(10'h041, 32'h12345678, 4'hF, rs);
    check("post_rst_bresp", rs, 2'b00);
    do_read(10'h041, rd, rs);
    check("post_rst_rdata", rd, 32'h12345678);
    check("post_rst_rresp", rs, 2'b00);
    check("post_rst_wr_cnt", wr_err_cnt, 8'd0);
    check("post_rst_rd_cnt", rd_err_cnt, 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
